// File: rtl/uart_matrix_tx_framer_pkg.sv
// Shared frame constants and FSM encodings for the UART matrix TX framer and RX assembler.
package uart_matrix_tx_framer_pkg;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
    localparam int         BYTES_PER_ELEM  = 8;
    localparam int         WORD_W          = 32;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR    = 4'd1,
        ST_FETCH  = 4'd2,
        ST_LATCH  = 4'd3,
        ST_SEND   = 4'd4,
        ST_GAP    = 4'd5,
        ST_WAITTX = 4'd6,
        ST_CKSUM  = 4'd7,
        ST_DONE   = 4'd8
    } tx_state_t;

    // Which part of the frame the shared GAP/WAITTX path returns to.
    typedef enum logic [1:0] {
        PH_HDR   = 2'd0,
        PH_DATA  = 2'd1,
        PH_CKSUM = 2'd2
    } tx_phase_t;

    function automatic logic [7:0] cksum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_matrix_tx_framer.sv
// Frames a NUM_ROWS x NUM_COLS complex float32 matrix from a word store into UART bytes:
// header, 8 payload bytes per element (re then im, MSB first), XOR checksum.
module uart_matrix_tx_framer
    import uart_matrix_tx_framer_pkg::*;
#(
    parameter int         NUM_ROWS    = 4,
    parameter int         NUM_COLS    = 2,
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
    parameter int         AW          = ((NUM_ROWS * NUM_COLS) > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [AW-1:0]     rd_addr,
    input  logic [WORD_W-1:0] rd_re,
    input  logic [WORD_W-1:0] rd_im,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    localparam int            NUM_ELEM      = NUM_ROWS * NUM_COLS;
    localparam logic [AW-1:0] LAST_ELEM     = AW'(NUM_ELEM - 1);
    localparam logic [AW-1:0] ADDR_ONE      = AW'(1);
    localparam logic [3:0]    ELEM_BYTES    = 4'(BYTES_PER_ELEM);

    tx_state_t     state_r, state_nxt_s;
    tx_phase_t     phase_r, phase_nxt_s;
    logic [AW-1:0] rd_addr_r, rd_addr_nxt_s;
    logic [AW-1:0] elem_cnt_r, elem_cnt_nxt_s;
    logic [3:0]    byte_cnt_r, byte_cnt_nxt_s;
    logic [63:0]   shift_r, shift_nxt_s;
    logic [7:0]    checksum_r, checksum_nxt_s;
    logic          tx_start_r, tx_start_nxt_s;
    logic [7:0]    tx_data_r, tx_data_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            phase_r    <= PH_HDR;
            rd_addr_r  <= '0;
            elem_cnt_r <= '0;
            byte_cnt_r <= 4'd0;
            shift_r    <= 64'd0;
            checksum_r <= 8'h00;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            phase_r    <= phase_nxt_s;
            rd_addr_r  <= rd_addr_nxt_s;
            elem_cnt_r <= elem_cnt_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            checksum_r <= checksum_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    // Next-state and next-register values; tx_start/done are one-cycle pulses.
    always_comb begin
        state_nxt_s    = state_r;
        phase_nxt_s    = phase_r;
        rd_addr_nxt_s  = rd_addr_r;
        elem_cnt_nxt_s = elem_cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        shift_nxt_s    = shift_r;
        checksum_nxt_s = checksum_r;
        tx_start_nxt_s = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    busy_nxt_s     = 1'b1;
                    rd_addr_nxt_s  = '0;
                    elem_cnt_nxt_s = '0;
                    byte_cnt_nxt_s = 4'd0;
                    checksum_nxt_s = 8'h00;
                    phase_nxt_s    = PH_HDR;
                    state_nxt_s    = ST_HDR;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!tx_busy) begin
                    tx_start_nxt_s = 1'b1;
                    tx_data_nxt_s  = HEADER_BYTE;
                    state_nxt_s    = ST_GAP;
                end else begin
                    state_nxt_s    = ST_HDR;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_LATCH;
            end
            ST_LATCH: begin
                shift_nxt_s    = {rd_re, rd_im};
                byte_cnt_nxt_s = 4'd0;
                state_nxt_s    = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_nxt_s  = shift_r[63:56];
                    tx_start_nxt_s = 1'b1;
                    checksum_nxt_s = cksum_update(checksum_r, shift_r[63:56]);
                    shift_nxt_s    = {shift_r[55:0], 8'h00};
                    byte_cnt_nxt_s = byte_cnt_r + 4'd1;
                    state_nxt_s    = ST_GAP;
                end else begin
                    state_nxt_s    = ST_SEND;
                end
            end
            // The transmitter raises busy one cycle after tx_start, so busy is not trusted here.
            ST_GAP: begin
                state_nxt_s = ST_WAITTX;
            end
            ST_WAITTX: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAITTX;
                end else begin
                    case (phase_r)
                        PH_HDR: begin
                            phase_nxt_s = PH_DATA;
                            state_nxt_s = ST_FETCH;
                        end
                        PH_DATA: begin
                            if (byte_cnt_r < ELEM_BYTES) begin
                                state_nxt_s = ST_SEND;
                            end else if (elem_cnt_r < LAST_ELEM) begin
                                elem_cnt_nxt_s = elem_cnt_r + ADDR_ONE;
                                rd_addr_nxt_s  = rd_addr_r + ADDR_ONE;
                                state_nxt_s    = ST_FETCH;
                            end else begin
                                phase_nxt_s = PH_CKSUM;
                                state_nxt_s = ST_CKSUM;
                            end
                        end
                        PH_CKSUM: begin
                            done_nxt_s  = 1'b1;
                            busy_nxt_s  = 1'b0;
                            state_nxt_s = ST_DONE;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_CKSUM: begin
                if (!tx_busy) begin
                    tx_start_nxt_s = 1'b1;
                    tx_data_nxt_s  = checksum_r;
                    state_nxt_s    = ST_GAP;
                end else begin
                    state_nxt_s    = ST_CKSUM;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign rd_addr  = rd_addr_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_uart_matrix_tx_framer.sv
// Randomized scoreboard bench for uart_matrix_tx_framer with store and transmitter models.
module tb_uart_matrix_tx_framer;

    localparam int N         = 8;
    localparam int FRAME_LEN = 2 + 8 * N;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  rd_addr;
    logic [31:0] rd_re;
    logic [31:0] rd_im;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        busy;
    logic        done;

    logic [31:0] mem_re [N];
    logic [31:0] mem_im [N];
    logic [7:0]  exp_q [$];

    int checks      = 0;
    int failures    = 0;
    int total_bytes = 0;
    int done_cnt    = 0;
    int hold_len    = 0;
    int busy_cnt    = 0;
    int cyc         = 0;
    int last_start  = -10;

    uart_matrix_tx_framer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_re    (rd_re),
        .rd_im    (rd_im),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .done     (done)
    );

    always #10 clk = ~clk;

    // Word store with one-cycle registered read.
    always @(posedge clk) begin
        rd_re <= mem_re[rd_addr];
        rd_im <= mem_im[rd_addr];
    end

    // Transmitter: busy rises the cycle after tx_start and holds for hold_len cycles (0 = random).
    always @(posedge clk) begin
        if (tx_start) begin
            busy_cnt <= (hold_len == 0) ? int'($urandom_range(1, 4)) : hold_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every byte handed to the transmitter.
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            chk("start_while_tx_busy", 64'(tx_busy), 64'd0);
            chk("start_spacing_ok", 64'((cyc - last_start) >= 2), 64'd1);
            last_start = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", 64'(tx_data), 64'hFFFF);
            end else begin
                chk("frame_byte", 64'(tx_data), 64'(exp_q.pop_front()));
            end
            total_bytes++;
        end
        if (done) begin
            done_cnt++;
        end
    end

    // Reference frame built from element words by plain shifting.
    task automatic push_expected();
        logic [7:0]  cks;
        logic [31:0] w;
        cks = 8'h00;
        exp_q.push_back(8'hA5);
        for (int e = 0; e < N; e++) begin
            for (int part = 0; part < 2; part++) begin
                w = (part == 0) ? mem_re[e] : mem_im[e];
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
                    cks = cks ^ 8'((w >> (8 * b)) & 32'hFF);
                end
            end
        end
        exp_q.push_back(cks);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic run_frame(input int hold, input bit extra_start, input int abort_at);
        int base_bytes;
        int base_done;
        int budget;
        bit pulsed;
        bit finished;
        hold_len   = hold;
        base_bytes = total_bytes;
        base_done  = done_cnt;
        push_expected();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        budget   = FRAME_LEN * (((hold == 0) ? 4 : hold) + 6) + 200;
        pulsed   = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != base_done) begin
                finished = 1'b1;
                break;
            end
            if (extra_start && !pulsed && (total_bytes - base_bytes) >= 10) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if (abort_at > 0 && (total_bytes - base_bytes) >= abort_at) begin
                reset_n = 1'b0;
                @(posedge clk); #1;
                check_reset_outputs("mid_reset");
                reset_n = 1'b1;
                exp_q.delete();
                repeat (5) @(posedge clk);
                #1;
                chk("no_done_on_abort", 64'(done_cnt), 64'(base_done));
                return;
            end
        end
        chk("frame_finished", 64'(finished), 64'd1);
        chk("busy_low_after_done", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("one_done_per_frame", 64'(done_cnt - base_done), 64'd1);
        chk("frame_length", 64'(total_bytes - base_bytes), 64'(FRAME_LEN));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("rd_addr_holds_last", 64'(rd_addr), 64'(N - 1));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic fill_random();
        for (int e = 0; e < N; e++) begin
            mem_re[e] = $urandom;
            mem_im[e] = $urandom;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int e = 0; e < N; e++) begin
            mem_re[e] = 32'h0;
            mem_im[e] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(0, 1'b0, 0);

        mem_re[0] = 32'h12345678;
        run_frame(2, 1'b0, 0);

        for (int k = 0; k < N; k++) begin
            mem_re[k] = 32'h3F800000 | 32'(k);
            mem_im[k] = 32'hC0000000 | 32'(k);
        end
        run_frame(0, 1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_frame(0, 1'b0, 0);
        end

        fill_random();
        run_frame(500, 1'b0, 0);

        fill_random();
        run_frame(0, 1'b1, 0);

        fill_random();
        run_frame(3, 1'b0, 30);
        fill_random();
        run_frame(0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
